// File: rtl/fwd_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl_pkg
//
// Shared types for the forwarding / hazard controller of the 5-stage core:
//   - reg_addr_t    : architectural register address
//   - fwd_sel_t     : operand forwarding mux select code
//   - ex/mem/wb entry structs : one shadow pipeline stage each, holding only
//                     the fields that stage actually needs downstream
//   - fwd_match()   : "this stage produces the register that EX reads"
// ---------------------------------------------------------------------------
package fwd_hazard_ctrl_pkg;

  localparam int PKG_REG_ADDR_W = 5;

  typedef logic [PKG_REG_ADDR_W-1:0] reg_addr_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_REGFILE = 2'b00;
  localparam fwd_sel_t FWD_MEMWB   = 2'b01;
  localparam fwd_sel_t FWD_EXMEM   = 2'b10;

  // ID/EX shadow entry: source registers are kept so forwarding can be
  // resolved for the instruction sitting in EX.
  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      rw;
    logic      mr;
  } ex_entry_t;

  // EX/MEM shadow entry: mr is kept so a load still in MEM is not used as a
  // forwarding source (its data does not exist yet).
  typedef struct packed {
    reg_addr_t rd;
    logic      rw;
    logic      mr;
  } mem_entry_t;

  // MEM/WB shadow entry: any register write here is forwardable.
  typedef struct packed {
    reg_addr_t rd;
    logic      rw;
  } wb_entry_t;

  localparam ex_entry_t  EX_BUBBLE  = '0;
  localparam mem_entry_t MEM_BUBBLE = '0;
  localparam wb_entry_t  WB_BUBBLE  = '0;

  // x0 is hard-wired zero, so a write to it is never a forwarding source.
  function automatic logic fwd_match(input logic      writes,
                                     input reg_addr_t rd,
                                     input reg_addr_t rs);
    return writes && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_fwd_sel_logic.sv
// ---------------------------------------------------------------------------
// fwd_sel_logic
//
// Purely combinational priority compare for one EX operand.
//   ex_rs_i : source register read by the instruction in EX (0 if unused)
//   mem_i   : EX/MEM shadow stage
//   wb_i    : MEM/WB shadow stage
//   sel_o   : FWD_EXMEM / FWD_MEMWB / FWD_REGFILE (never 2'b11)
// ---------------------------------------------------------------------------
module fwd_sel_logic
  import fwd_hazard_ctrl_pkg::*;
(
  input  reg_addr_t  ex_rs_i,
  input  mem_entry_t mem_i,
  input  wb_entry_t  wb_i,
  output fwd_sel_t   sel_o
);

  // EX/MEM is checked first: when both stages write the same register the
  // younger result is the architecturally correct one.
  always_comb begin
    sel_o = FWD_REGFILE;
    if (fwd_match(mem_i.rw && !mem_i.mr, mem_i.rd, ex_rs_i)) begin
      sel_o = FWD_EXMEM;
    end else if (fwd_match(wb_i.rw, wb_i.rd, ex_rs_i)) begin
      sel_o = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Forwarding-select and load-use hazard controller for the 5-stage core.
// Keeps a shadow copy of ID/EX, EX/MEM and MEM/WB register addresses and
// control bits, drives the two EX operand forwarding mux selects, and
// raises a one-cycle stall for a load followed directly by a user.
//
// Parameters
//   REG_ADDR_W : register address width (the shadow entries store
//                PKG_REG_ADDR_W bits)
//   CNT_W      : width of the saturating stall statistics counter
//
// Ports
//   clk, rst_n                      : clock, asynchronous active-low reset
//   id_valid                        : ID holds a real instruction
//   id_rs1, id_rs2                  : ID source registers
//   id_uses_rs1, id_uses_rs2        : ID instruction reads rs1 / rs2
//   id_rd, id_reg_write, id_mem_read: ID destination, writes-rd, is-load
//   flush                           : taken branch in EX, kill ID
//   fwd_a_sel, fwd_b_sel            : operand A / B forwarding selects
//   stall                           : hold PC and IF/ID this cycle
//   stall_cnt                       : saturating count of stall cycles
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_cnt
);

  ex_entry_t        ex_q,  ex_d;
  mem_entry_t       mem_q, mem_d;
  wb_entry_t        wb_q,  wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  reg_addr_t id_rs1_a, id_rs2_a, id_rd_a;

  assign id_rs1_a = reg_addr_t'(id_rs1);
  assign id_rs2_a = reg_addr_t'(id_rs2);
  assign id_rd_a  = reg_addr_t'(id_rd);

  // Load-use hazard: the load in EX has no data until it leaves MEM, so a
  // dependent instruction in ID must wait one cycle. A flush kills the ID
  // instruction anyway, so it suppresses the stall.
  always_comb begin
    stall = 1'b0;
    if (!flush && id_valid && ex_q.mr && (ex_q.rd != '0)) begin
      stall = (id_uses_rs1 && (id_rs1_a == ex_q.rd)) ||
              (id_uses_rs2 && (id_rs2_a == ex_q.rd));
    end
  end

  // ID/EX capture. Unused source fields are zeroed so they can never match
  // a producer (x0 is excluded from forwarding).
  always_comb begin
    ex_d = EX_BUBBLE;
    if (id_valid && !flush && !stall) begin
      ex_d.rs1 = id_uses_rs1 ? id_rs1_a : '0;
      ex_d.rs2 = id_uses_rs2 ? id_rs2_a : '0;
      ex_d.rd  = id_rd_a;
      ex_d.rw  = id_reg_write;
      ex_d.mr  = id_mem_read;
    end
  end

  // Downstream stages never stall; they simply follow the pipeline.
  always_comb begin
    mem_d = '{rd: ex_q.rd,  rw: ex_q.rw,  mr: ex_q.mr};
    wb_d  = '{rd: mem_q.rd, rw: mem_q.rw};
  end

  // Saturating statistics counter: holds at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= EX_BUBBLE;
      mem_q <= MEM_BUBBLE;
      wb_q  <= WB_BUBBLE;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;

  fwd_sel_logic u_fwd_a (
    .ex_rs_i (ex_q.rs1),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_o   (fwd_a_sel)
  );

  fwd_sel_logic u_fwd_b (
    .ex_rs_i (ex_q.rs2),
    .mem_i   (mem_q),
    .wb_i    (wb_q),
    .sel_o   (fwd_b_sel)
  );

endmodule
